// File: rtl/pkt_writer.sv
// Ingress packet writer: packs a byte stream into 32-bit words and writes them to packet SRAM, then starts proc.
// Latency: word write in the cycle after its 4th byte is accepted; start pulse once proc_ready_i is high in NOTIFY.
// Backpressure: s_ready_o drops only during WORD/TAIL write cycles and outside RECV; bytes past MAX_LEN are accepted and dropped.
module pkt_writer #(
    parameter int MAX_LEN = 1536,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              s_valid_i,
    input  logic [7:0]        s_data_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_width_o,
    output logic [31:0]       mem_data_o,
    input  logic              proc_ready_i,
    output logic              proc_start_o,
    output logic [ADDR_W-1:0] pkt_addr_o,
    output logic [15:0]       pkt_len_o,
    output logic              trunc_o,
    output logic              busy_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RECV   = 3'd1;
    localparam logic [2:0] S_WORD   = 3'd2;
    localparam logic [2:0] S_TAIL   = 3'd3;
    localparam logic [2:0] S_NOTIFY = 3'd4;

    logic [2:0]        state, nxt_state;
    logic [ADDR_W-1:0] base;
    logic [15:0]       count;
    logic [31:0]       buffer;
    logic              last_seen;
    logic              tail_hi;
    logic              trunc;
    logic [ADDR_W-1:0] pkt_addr;
    logic [15:0]       pkt_len;

    logic              accept;
    logic              full;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] word_off;

    assign accept   = s_valid_i && (state == S_RECV);
    assign full     = (count == 16'(MAX_LEN));
    assign lane     = count[1:0];
    assign word_off = ADDR_W'({count[15:2], 2'b00});

    always_comb begin
        nxt_state = state;
        case (state)
            S_IDLE:   if (start_i) nxt_state = S_RECV;
            S_RECV: begin
                if (accept) begin
                    if (full) begin
                        if (s_last_i) nxt_state = S_NOTIFY;
                    end else if (lane == 2'd3) begin
                        nxt_state = S_WORD;
                    end else if (s_last_i) begin
                        nxt_state = S_TAIL;
                    end
                end
            end
            S_WORD:   nxt_state = last_seen ? S_NOTIFY : S_RECV;
            // A 3-byte remainder needs a halfword cycle followed by a byte cycle.
            S_TAIL:   nxt_state = (lane == 2'd3 && !tail_hi) ? S_TAIL : S_NOTIFY;
            S_NOTIFY: if (proc_ready_i) nxt_state = S_IDLE;
            default:  nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            base      <= '0;
            count     <= '0;
            buffer    <= '0;
            last_seen <= 1'b0;
            tail_hi   <= 1'b0;
            trunc     <= 1'b0;
            pkt_addr  <= '0;
            pkt_len   <= '0;
        end else begin
            state <= nxt_state;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        base      <= base_addr_i & ~ADDR_W'(3);
                        count     <= '0;
                        buffer    <= '0;
                        last_seen <= 1'b0;
                        tail_hi   <= 1'b0;
                        trunc     <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (accept) begin
                        last_seen <= s_last_i;
                        if (full) begin
                            trunc <= 1'b1;
                        end else begin
                            buffer[{lane, 3'b000} +: 8] <= s_data_i;
                            count                       <= count + 16'd1;
                        end
                    end
                end
                S_WORD:  buffer  <= '0;
                S_TAIL:  tail_hi <= (nxt_state == S_TAIL);
                default: ;
            endcase
            // Publish packet info on entry to NOTIFY so it is valid during the start pulse.
            if (state != S_NOTIFY && nxt_state == S_NOTIFY) begin
                pkt_addr <= base;
                pkt_len  <= count;
            end
        end
    end

    always_comb begin
        mem_ce_o    = 1'b0;
        mem_addr_o  = '0;
        mem_width_o = 4'd0;
        mem_data_o  = '0;
        if (state == S_WORD) begin
            mem_ce_o    = 1'b1;
            mem_addr_o  = base + ADDR_W'(count) - ADDR_W'(4);
            mem_width_o = 4'd4;
            mem_data_o  = buffer;
        end else if (state == S_TAIL) begin
            mem_ce_o = 1'b1;
            if (lane == 2'd1) begin
                mem_addr_o  = base + word_off;
                mem_width_o = 4'd1;
                mem_data_o  = {24'd0, buffer[7:0]};
            end else if (tail_hi) begin
                mem_addr_o  = base + word_off + ADDR_W'(2);
                mem_width_o = 4'd1;
                mem_data_o  = {24'd0, buffer[23:16]};
            end else begin
                mem_addr_o  = base + word_off;
                mem_width_o = 4'd2;
                mem_data_o  = {16'd0, buffer[15:0]};
            end
        end
    end

    assign mem_we_o     = mem_ce_o;
    assign s_ready_o    = (state == S_RECV);
    assign proc_start_o = (state == S_NOTIFY) && proc_ready_i;
    assign pkt_addr_o   = pkt_addr;
    assign pkt_len_o    = pkt_len;
    assign trunc_o      = trunc;
    assign busy_o       = (state != S_IDLE);

endmodule

// File: tb/tb_pkt_writer.sv
// Bench for pkt_writer with MAX_LEN=8: directed table, hand-written corner sequences and random packets vs a byte-level model.
module tb_pkt_writer;

    localparam int ML = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, s_valid_i, s_last_i, proc_ready_i;
    logic [31:0] base_addr_i;
    logic [7:0]  s_data_i;
    logic        s_ready_o, mem_ce_o, mem_we_o, proc_start_o, trunc_o, busy_o;
    logic [31:0] mem_addr_o, mem_data_o, pkt_addr_o;
    logic [3:0]  mem_width_o;
    logic [15:0] pkt_len_o;

    pkt_writer #(.MAX_LEN(ML), .ADDR_W(32)) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_width_o(mem_width_o), .mem_data_o(mem_data_o),
        .proc_ready_i(proc_ready_i), .proc_start_o(proc_start_o),
        .pkt_addr_o(pkt_addr_o), .pkt_len_o(pkt_len_o), .trunc_o(trunc_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [3:0] width; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] addr; logic [15:0] len; logic trunc; } pk_t;
    typedef struct {
        logic [31:0] base; int n; logic [7:0] d0;
        logic [31:0] exp_addr; int exp_len; bit exp_trunc; int exp_nwr; int exp_stall; logic [31:0] exp_wd0;
    } vec_t;

    wr_t        got_wr[$];
    pk_t        got_pkt[$];
    wr_t        exp_wr[$];
    logic [7:0] pkt_bytes[$];
    int         we_err = 0;
    int         total = 0;
    int         bad = 0;

    always @(negedge clk) begin
        if (mem_ce_o !== mem_we_o) we_err++;
        if (mem_ce_o) got_wr.push_back('{mem_addr_o, mem_width_o, mem_data_o});
        if (proc_start_o) got_pkt.push_back('{pkt_addr_o, pkt_len_o, trunc_o});
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_pkt(input logic [31:0] b);
        start_i = 1'b1;
        base_addr_i = b;
        tick();
        start_i = 1'b0;
        base_addr_i = $urandom;
    endtask

    task automatic put_byte(input logic [7:0] b, input bit last, input bit inj, output int stalls);
        bit acc, r;
        s_valid_i = 1'b1; s_data_i = b; s_last_i = last;
        if (inj) begin start_i = 1'b1; base_addr_i = 32'h80; end
        stalls = 0; acc = 0;
        for (int k = 0; k < 50 && !acc; k++) begin
            #1 r = s_ready_o;
            tick();
            if (r) acc = 1; else stalls++;
        end
        s_valid_i = 1'b0; s_last_i = 1'b0; start_i = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Sends pkt_bytes as one packet; optional random valid gaps and a stray start_i at byte inj_at.
    task automatic send(input logic [31:0] b, input bit gaps, input int inj_at, output int stalls);
        int s;
        begin_pkt(b);
        stalls = 0;
        for (int i = 0; i < pkt_bytes.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) tick();
            put_byte(pkt_bytes[i], i == pkt_bytes.size() - 1, i == inj_at, s);
            stalls += s;
        end
    endtask

    task automatic wait_pulse(input bit rand_ready);
        int k;
        for (k = 0; k < 200 && got_pkt.size() == 0; k++) begin
            if (rand_ready) proc_ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        proc_ready_i = 1'b1;
        if (got_pkt.size() == 0) chk("pulse_timeout", 32'd0, 32'd1);
    endtask

    // Reference: bytes beyond ML dropped; whole words first, then halfword/byte remainder in address order.
    task automatic compare_model(input logic [31:0] b, input string tag);
        int n, kept, r, t;
        logic [31:0] a;
        n = pkt_bytes.size();
        kept = (n > ML) ? ML : n;
        a = b & ~32'd3;
        exp_wr.delete();
        for (int w = 0; w < kept / 4; w++)
            exp_wr.push_back('{a + 32'(4 * w), 4'd4,
                {pkt_bytes[4*w+3], pkt_bytes[4*w+2], pkt_bytes[4*w+1], pkt_bytes[4*w]}});
        r = kept % 4;
        t = kept - r;
        if (r == 1) exp_wr.push_back('{a + 32'(t), 4'd1, {24'd0, pkt_bytes[t]}});
        if (r >= 2) exp_wr.push_back('{a + 32'(t), 4'd2, {16'd0, pkt_bytes[t+1], pkt_bytes[t]}});
        if (r == 3) exp_wr.push_back('{a + 32'(t + 2), 4'd1, {24'd0, pkt_bytes[t+2]}});
        chk($sformatf("%s nwr", tag), 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            chk($sformatf("%s wr%0d addr", tag, i), got_wr[i].addr, exp_wr[i].addr);
            chk($sformatf("%s wr%0d width", tag, i), 32'(got_wr[i].width), 32'(exp_wr[i].width));
            chk($sformatf("%s wr%0d data", tag, i), got_wr[i].data, exp_wr[i].data);
        end
        if (got_pkt.size() > 0) begin
            chk($sformatf("%s pkt_addr", tag), got_pkt[0].addr, a);
            chk($sformatf("%s pkt_len", tag), 32'(got_pkt[0].len), 32'(kept));
            chk($sformatf("%s trunc", tag), 32'(got_pkt[0].trunc), 32'(n > ML));
        end
        chk($sformatf("%s npulse", tag), 32'(got_pkt.size()), 32'd1);
        chk($sformatf("%s busy_after", tag), 32'(busy_o), 32'd0);
        got_wr.delete();
        got_pkt.delete();
    endtask

    task automatic fill_seq(input int n, input logic [7:0] d0);
        pkt_bytes.delete();
        for (int i = 0; i < n; i++) pkt_bytes.push_back(d0 + 8'(i));
    endtask

    vec_t tbl[8];

    initial begin
        int st;
        logic [31:0] b;
        tbl[0] = '{32'h04,       8,  8'h00, 32'h04,       8, 1'b0, 2, 1, 32'h03020100};
        tbl[1] = '{32'h10,       7,  8'h11, 32'h10,       7, 1'b0, 3, 1, 32'h14131211};
        tbl[2] = '{32'h20,       1,  8'hA5, 32'h20,       1, 1'b0, 1, 0, 32'h000000A5};
        tbl[3] = '{32'h33,       2,  8'h5A, 32'h30,       2, 1'b0, 1, 0, 32'h00005B5A};
        tbl[4] = '{32'h44,       11, 8'h30, 32'h44,       8, 1'b1, 2, 2, 32'h33323130};
        tbl[5] = '{32'hFFFFFFFC, 6,  8'h60, 32'hFFFFFFFC, 6, 1'b0, 2, 1, 32'h63626160};
        tbl[6] = '{32'h50,       4,  8'h70, 32'h50,       4, 1'b0, 1, 0, 32'h73727170};
        tbl[7] = '{32'h60,       9,  8'h80, 32'h60,       8, 1'b1, 2, 2, 32'h83828180};

        rst = 1'b0; start_i = 0; s_valid_i = 0; s_last_i = 0; s_data_i = 0;
        base_addr_i = 0; proc_ready_i = 1'b1;
        repeat (3) tick();
        chk("reset s_ready", 32'(s_ready_o), 0);
        chk("reset mem_ce", 32'(mem_ce_o), 0);
        chk("reset busy", 32'(busy_o), 0);
        chk("reset pkt_len", 32'(pkt_len_o), 0);
        rst = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            fill_seq(tbl[v].n, tbl[v].d0);
            send(tbl[v].base, 1'b0, -1, st);
            chk($sformatf("t%0d stalls", v), 32'(st), 32'(tbl[v].exp_stall));
            wait_pulse(1'b0);
            chk($sformatf("t%0d nwr_tbl", v), 32'(got_wr.size()), 32'(tbl[v].exp_nwr));
            if (got_wr.size() > 0) chk($sformatf("t%0d wd0", v), got_wr[0].data, tbl[v].exp_wd0);
            if (got_pkt.size() > 0) begin
                chk($sformatf("t%0d addr_tbl", v), got_pkt[0].addr, tbl[v].exp_addr);
                chk($sformatf("t%0d len_tbl", v), 32'(got_pkt[0].len), 32'(tbl[v].exp_len));
                chk($sformatf("t%0d trunc_tbl", v), 32'(got_pkt[0].trunc), 32'(tbl[v].exp_trunc));
            end
            compare_model(tbl[v].base, $sformatf("t%0d", v));
        end

        // Word write lands in the cycle right after the 4th byte.
        begin_pkt(32'hA0);
        for (int i = 0; i < 4; i++) put_byte(8'hC0 + 8'(i), 1'b0, 1'b0, st);
        chk("lat mem_ce", 32'(mem_ce_o), 1);
        chk("lat addr", mem_addr_o, 32'hA0);
        chk("lat s_ready", 32'(s_ready_o), 0);
        put_byte(8'hC4, 1'b1, 1'b0, st);
        fill_seq(5, 8'hC0);
        wait_pulse(1'b0);
        compare_model(32'hA0, "lat");

        // proc_ready_i held low: start waits in NOTIFY.
        proc_ready_i = 1'b0;
        fill_seq(5, 8'h21);
        send(32'h70, 1'b0, -1, st);
        repeat (10) tick();
        chk("hold npulse", 32'(got_pkt.size()), 0);
        chk("hold busy", 32'(busy_o), 1);
        proc_ready_i = 1'b1;
        #1 chk("hold pulse", 32'(proc_start_o), 1);
        tick();
        compare_model(32'h70, "hold");

        // Stray start_i with a different base during RECV.
        fill_seq(6, 8'h90);
        send(32'h90, 1'b0, 2, st);
        wait_pulse(1'b0);
        compare_model(32'h90, "inj");

        // Reset in the middle of a packet abandons it.
        begin_pkt(32'h20);
        for (int i = 0; i < 6; i++) put_byte(8'(i), 1'b0, 1'b0, st);
        rst = 1'b0;
        #1;
        chk("mid_rst s_ready", 32'(s_ready_o), 0);
        chk("mid_rst mem_ce", 32'(mem_ce_o), 0);
        chk("mid_rst proc_start", 32'(proc_start_o), 0);
        chk("mid_rst pkt_addr", pkt_addr_o, 0);
        chk("mid_rst pkt_len", 32'(pkt_len_o), 0);
        chk("mid_rst trunc", 32'(trunc_o), 0);
        chk("mid_rst busy", 32'(busy_o), 0);
        got_wr.delete();
        s_valid_i = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        repeat (3) tick();
        s_valid_i = 1'b0;
        chk("mid_rst no_wr", 32'(got_wr.size()), 0);
        fill_seq(4, 8'hE0);
        send(32'h40, 1'b0, -1, st);
        wait_pulse(1'b0);
        compare_model(32'h40, "post_rst");

        for (int p = 0; p < 40; p++) begin
            pkt_bytes.delete();
            repeat ($urandom_range(1, 14)) pkt_bytes.push_back(8'($urandom));
            b = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
            proc_ready_i = 1'($urandom_range(0, 1));
            send(b, 1'b1, ($urandom_range(0, 3) == 0) ? 1 : -1, st);
            wait_pulse(1'b1);
            compare_model(b, $sformatf("rnd%0d", p));
        end

        chk("we_equals_ce", 32'(we_err), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
